// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if
//
// Purpose: groups the signals exchanged between the UART receiver and the
// APB UART register block. The configuration comes from the register block,
// and the received character and status flags go back to it.
//
// Signals:
//   RxEn       receiver enable (ControlReg0[1])
//   UBRR       baud divisor; tick period is UBRR+1 clock cycles
//   DLS        data length select; data bits = 5+DLS
//   STOP       0 = one stop bit, 1 = two stop bits
//   PEN        parity enable
//   EPS        1 = even parity, 0 = odd parity
//   RxData     received character, right-justified, unused MSBs 0
//   RxDone     one-cycle pulse when a frame completes
//   RxStopBit  1 = all stop bits sampled high (valid with RxDone)
//   ParityErr  parity mismatch (valid with RxDone, 0 when PEN=0)
//   Busy       receiver is inside a frame
//
// Modports:
//   master  register-block side (drives configuration, reads results)
//   slave   receiver side (reads configuration, drives results)
// ---------------------------------------------------------------------------
interface uart_rx_if #(
    parameter int UBRR_W = 12
);
    logic              RxEn;
    logic [UBRR_W-1:0] UBRR;
    logic [1:0]        DLS;
    logic              STOP;
    logic              PEN;
    logic              EPS;
    logic [7:0]        RxData;
    logic              RxDone;
    logic              RxStopBit;
    logic              ParityErr;
    logic              Busy;

    modport master (
        output RxEn, UBRR, DLS, STOP, PEN, EPS,
        input  RxData, RxDone, RxStopBit, ParityErr, Busy
    );

    modport slave (
        input  RxEn, UBRR, DLS, STOP, PEN, EPS,
        output RxData, RxDone, RxStopBit, ParityErr, Busy
    );
endinterface

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//
// Purpose: oversampling serial receiver feeding the APB UART register block.
// The asynchronous Rx line is synchronised, a baud tick is derived from UBRR,
// and frames of 5-8 data bits (LSB first), optional parity and one or two
// stop bits are decoded. A completed frame produces a one-cycle RxDone pulse
// together with RxData, RxStopBit and ParityErr, which hold until the next
// completed frame.
//
// Ports:
//   pClk    system clock
//   pReset  asynchronous active-low reset
//   Rx      serial line (asynchronous, idle high)
//   bus     uart_rx_if.slave: configuration in, RxData/RxDone/RxStopBit/
//           ParityErr/Busy out
//
// Parameters:
//   OVERSAMPLE  baud ticks per bit period (even, >= 8)
//   UBRR_W      width of the baud divisor
//
// Build option:
//   UART_RX_MAJORITY_EN  when defined, every bit is the 2-of-3 majority of
//                        three consecutive tick samples around mid-bit; the
//                        decision is taken one tick later than the default
//                        single-sample receiver.
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int UBRR_W     = 12
) (
    input  logic     pClk,
    input  logic     pReset,
    input  logic     Rx,
    uart_rx_if.slave bus
);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [CNT_W-1:0] START_DEC = CNT_W'(OVERSAMPLE / 2);
`else
    localparam logic [CNT_W-1:0] START_DEC = CNT_W'(OVERSAMPLE / 2 - 1);
`endif

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP1  = 3'd4;
    localparam logic [2:0] STOP2  = 3'd5;

    // ---------------- synchroniser and start-edge detect ----------------
    logic rx_meta_reg;
    logic rx_s_reg;
    logic rx_prev_reg;
    logic start_edge;

    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= Rx;
            rx_s_reg    <= rx_meta_reg;
            rx_prev_reg <= rx_s_reg;
        end
    end

    // rx_prev tracks the line in every state, so a line that is still low
    // when the FSM returns to IDLE cannot be mistaken for a new start edge.
    assign start_edge = rx_prev_reg & ~rx_s_reg;

    // ---------------- baud tick ----------------
    logic [UBRR_W-1:0] baud_cnt_reg;
    logic              tick;

    // >= rather than == keeps the counter from running the full range if
    // UBRR is lowered while the counter is above the new value.
    assign tick = bus.RxEn && (baud_cnt_reg >= bus.UBRR);

    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            baud_cnt_reg <= '0;
        end else if (!bus.RxEn || tick) begin
            baud_cnt_reg <= '0;
        end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
        end
    end

    // ---------------- FSM and datapath state ----------------
    logic [2:0]       state_reg;
    logic [2:0]       state_next;
    logic [CNT_W-1:0] tick_cnt_reg;
    logic [2:0]       bit_idx_reg;
    logic [7:0]       data_sh_reg;
    logic [1:0]       dls_reg;
    logic             stop_reg;
    logic             pen_reg;
    logic             eps_reg;
    logic             stop_ok_reg;
    logic             par_calc_reg;
    logic [7:0]       rx_data_reg;
    logic             done_reg;
    logic             stop_bit_reg;
    logic             parity_err_reg;

    logic [CNT_W-1:0] dec_cnt;
    logic             at_dec;
    logic             bit_val;
    logic             frame_done;
    logic [2:0]       last_idx;
    logic [7:0]       data_mask;

    // The start bit is decided half a bit after the edge; every later bit a
    // full bit period after the previous decision, which lands it mid-bit.
    assign dec_cnt  = (state_reg == START) ? START_DEC : LAST_CNT;
    assign at_dec   = tick && (tick_cnt_reg == dec_cnt);
    assign last_idx = {1'b0, dls_reg} + 3'd4;

    for (genvar gi = 0; gi < 8; gi++) begin : g_mask
        assign data_mask[gi] = (3'(gi) <= last_idx);
    end

`ifdef UART_RX_MAJORITY_EN
    logic maj_a_reg;
    logic maj_b_reg;

    // Collect the two samples preceding the decision tick; the third sample
    // is rx_s itself at the decision tick.
    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            maj_a_reg <= 1'b1;
            maj_b_reg <= 1'b1;
        end else if (tick) begin
            if (tick_cnt_reg == dec_cnt - CNT_W'(2)) maj_a_reg <= rx_s_reg;
            if (tick_cnt_reg == dec_cnt - CNT_W'(1)) maj_b_reg <= rx_s_reg;
        end
    end

    assign bit_val = (maj_a_reg & maj_b_reg) | (maj_a_reg & rx_s_reg) |
                     (maj_b_reg & rx_s_reg);
`else
    assign bit_val = rx_s_reg;
`endif

    always_comb begin
        state_next = state_reg;
        frame_done = 1'b0;
        if (!bus.RxEn) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:   if (start_edge) state_next = START;
                START:  if (at_dec) state_next = bit_val ? IDLE : DATA;
                DATA:   if (at_dec && (bit_idx_reg == last_idx))
                            state_next = pen_reg ? PARITY : STOP1;
                PARITY: if (at_dec) state_next = STOP1;
                STOP1:  if (at_dec) begin
                            if (stop_reg) begin
                                state_next = STOP2;
                            end else begin
                                state_next = IDLE;
                                frame_done = 1'b1;
                            end
                        end
                STOP2:  if (at_dec) begin
                            state_next = IDLE;
                            frame_done = 1'b1;
                        end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            state_reg      <= IDLE;
            tick_cnt_reg   <= '0;
            bit_idx_reg    <= '0;
            data_sh_reg    <= '0;
            dls_reg        <= '0;
            stop_reg       <= 1'b0;
            pen_reg        <= 1'b0;
            eps_reg        <= 1'b0;
            stop_ok_reg    <= 1'b0;
            par_calc_reg   <= 1'b0;
            rx_data_reg    <= '0;
            done_reg       <= 1'b0;
            stop_bit_reg   <= 1'b0;
            parity_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= frame_done;

            // DATA stays in one state across bits; its counter simply wraps.
            if (state_next != state_reg) begin
                tick_cnt_reg <= '0;
            end else if (tick) begin
                tick_cnt_reg <= (tick_cnt_reg == LAST_CNT) ? '0 : tick_cnt_reg + 1'b1;
            end

            // Frame format is frozen at the start edge.
            if (state_reg == IDLE && state_next == START) begin
                dls_reg      <= bus.DLS;
                stop_reg     <= bus.STOP;
                pen_reg      <= bus.PEN;
                eps_reg      <= bus.EPS;
                data_sh_reg  <= '0;
                bit_idx_reg  <= '0;
                stop_ok_reg  <= 1'b1;
                par_calc_reg <= 1'b0;
            end

            if (at_dec) begin
                case (state_reg)
                    DATA: begin
                        data_sh_reg[bit_idx_reg] <= bit_val;
                        bit_idx_reg              <= bit_idx_reg + 3'd1;
                    end
                    // Unreceived data bits are 0, so the full-width XOR
                    // covers exactly the received bits.
                    PARITY:       par_calc_reg <= bit_val ^ (^data_sh_reg) ^ ~eps_reg;
                    STOP1, STOP2: stop_ok_reg  <= stop_ok_reg & bit_val;
                    default: ;
                endcase
            end

            // The last stop sample is folded in directly so the results are
            // registered in the same cycle it is taken.
            if (frame_done) begin
                rx_data_reg    <= data_sh_reg & data_mask;
                stop_bit_reg   <= stop_ok_reg & bit_val;
                parity_err_reg <= par_calc_reg & pen_reg;
            end
        end
    end

    assign bus.RxData    = rx_data_reg;
    assign bus.RxDone    = done_reg;
    assign bus.RxStopBit = stop_bit_reg;
    assign bus.ParityErr = parity_err_reg;
    assign bus.Busy      = (state_reg != IDLE);
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver directly upstream of the APB UART register block.
- Oversamples the synchronised Rx line with a baud tick derived from UBRR and frames 5–8 data bits, optional parity and 1 or 2 stop bits.
- Delivers RxData, a one-cycle RxDone pulse and the RxStopBit framing flag; the register block captures these into its Rx buffer/FIFO and status register.

Parameters:
- OVERSAMPLE, 16, baud ticks per bit period; must be even and >= 8.
- UBRR_W, 12, width of the baud-rate divisor: ControlReg0[7:4] concatenated with UBRR[7:0].

Ports:
- pClk  input  1  system clock
- pReset  input  1  asynchronous active-low reset
- RxEn  input  1  receiver enable (ControlReg0[1])
- UBRR  input  UBRR_W  baud divisor; tick period is UBRR+1 pClk cycles
- DLS  input  2  data length select; data bits = 5+DLS
- STOP  input  1  0 = one stop bit, 1 = two stop bits
- PEN  input  1  parity enable
- EPS  input  1  1 = even parity, 0 = odd parity
- Rx  input  1  serial line, asynchronous, idle high
- RxData  output  8  received character, right-justified, unused MSBs 0
- RxDone  output  1  one-pClk pulse when a frame completes
- RxStopBit  output  1  1 = all stop bits sampled high; valid with RxDone
- ParityErr  output  1  parity mismatch; valid with RxDone; 0 when PEN=0
- Busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values: RxData=0, RxDone=0, RxStopBit=0, ParityErr=0, Busy=0; FSM in IDLE; all counters 0; synchroniser flops 1.
- Synchroniser: two-flop synchroniser on Rx. All sampling uses the second flop (rx_s).
- Baud counter:
  - Free-runs while RxEn=1; held at 0 while RxEn=0.
  - Counts 0..UBRR; tick is asserted for one cycle when count==UBRR, then count wraps to 0.
  - UBRR=0 gives a tick every cycle.
- Tick counter: 0..OVERSAMPLE-1, advances on tick, cleared on every FSM state entry.
- FSM states and transitions:
  - IDLE: on a falling edge of rx_s with RxEn=1, latch DLS/STOP/PEN/EPS into shadow registers, clear the tick counter and go to START. Configuration changes mid-frame have no effect.
  - START: at tick count OVERSAMPLE/2-1 (mid-bit), sample rx_s. If 1 (false start), go to IDLE with no RxDone. If 0, go to DATA.
  - DATA: sample every OVERSAMPLE ticks, LSB first. Bit k goes to data_sh[k]. After 5+DLS bits go to PARITY if PEN=1, else STOP1.
  - PARITY: sample one bit. ParityErr = sampled ^ (^data_bits) ^ EPS_n, where EPS_n = ~EPS (even parity: XOR of data and parity bits = 0).
  - STOP1: sample one bit. If STOP=1 go to STOP2, else finish.
  - STOP2: sample one bit, then finish.
  - Finish: in the same cycle as the last stop sample, register RxData (bits above 5+DLS forced to 0), RxStopBit = AND of the sampled stop bits, ParityErr, and RxDone=1 for exactly one cycle. Then return to IDLE. The next falling edge can start a new frame immediately (half-stop-bit resynchronisation).
- Output holding: RxData, RxStopBit and ParityErr hold until the next RxDone.
- Framing error: a stop bit sampled low still completes the frame with RxStopBit=0. Line low at the return to IDLE is not treated as a start edge until rx_s has been seen high.
- RxEn falling mid-frame: the FSM goes to IDLE on the next cycle. No RxDone; outputs hold their previous values.
- Reset mid-frame: all state clears asynchronously, with no RxDone pulse.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each bit (start, data, parity, stop) is taken as the 2-of-3 majority of rx_s at tick counts OVERSAMPLE/2-2, -1 and 0. The decision and transition happen at tick OVERSAMPLE/2.
- Not defined: single sample at tick OVERSAMPLE/2-1, as described in Behaviour. Frame latency is one tick shorter than with the feature defined.

Test Plan:
- UBRR=3, DLS=3, PEN=0, STOP=0, send 0xA5 with 64 pClk per bit -> one RxDone pulse; RxData=0xA5, RxStopBit=1, ParityErr=0; RxDone asserts about 9.5 bit periods after the start edge.
- DLS=0, PEN=1, EPS=1, send 5-bit value 0x13 with correct even parity, then the same value with the parity bit flipped -> RxData=0x13 both times; ParityErr=0, then 1.
- STOP=1, second stop bit driven low -> RxDone=1, RxStopBit=0, RxData correct.
- 16 pClk low glitch on idle line (UBRR=3) -> no RxDone; Busy returns to 0; the next valid frame (0x3C) is received correctly.
- Drop RxEn after 3 data bits -> no RxDone, Busy=0 within 1 cycle; RxData keeps its prior value. Re-enable and send 0x7E -> received 0x7E.
- Back-to-back frames 0x55, 0xAA with a single stop bit, plus an async reset asserted mid-second-frame -> first RxDone with 0x55. After reset all outputs are 0, and there is no RxDone for the aborted frame.
